// File: rtl/syn_fifo_flag_pkg.sv
// Shared definitions for the single-clock flagged FIFO and its storage array.
package syn_fifo_flag_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/syn_fifo_flag_ram.sv
// 1-write/1-read register array: synchronous write, asynchronous read, no reset.
module fifo_ram
    import syn_fifo_flag_pkg::*;
#(
    parameter int depth      = 8,
    parameter int data_width = 8
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_w(depth)-1:0]     waddr,
    input  logic [data_width-1:0]       wdata,
    input  logic [ptr_w(depth)-1:0]     raddr,
    output logic [data_width-1:0]       rdata
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_flag.sv
// Single-clock FIFO with arbitrary depth, threshold flags, occupancy, error pulses, flush.
// Read latency 1 cycle (std) or 0 (fwft); rejected writes/reads raise a pulse the next cycle.
module syn_fifo_flag
    import syn_fifo_flag_pkg::*;
#(
    parameter int depth      = 8,
    parameter int data_width = 8,
    parameter int afull_th   = 6,
    parameter int aempty_th  = 1,
    parameter int fwft       = FIFO_STD
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        flush,
    input  logic                        w_en,
    input  logic [data_width-1:0]       data_in,
    input  logic                        r_en,
    output logic [data_width-1:0]       data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_w(depth)-1:0]     cnt,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int PW = ptr_w(depth);
    localparam int CW = cnt_w(depth);
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(depth);
    localparam logic [CW-1:0] AF_TH    = CW'(afull_th);
    localparam logic [CW-1:0] AE_TH    = CW'(aempty_th);

    if (depth < 2) begin : g_bad_depth
        $error("syn_fifo_flag: depth must be >= 2");
    end
    if (afull_th < 1 || afull_th > depth) begin : g_bad_afull
        $error("syn_fifo_flag: afull_th out of range 1..depth");
    end
    if (aempty_th < 0 || aempty_th > depth - 1) begin : g_bad_aempty
        $error("syn_fifo_flag: aempty_th out of range 0..depth-1");
    end

    logic [PW-1:0]         w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  w_acc, r_acc;
    logic [data_width-1:0] rd_data;

    assign full         = (cnt_q == CNT_FULL);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AF_TH);
    assign almost_empty = (cnt_q <= AE_TH);
    assign cnt          = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Full/empty gate acceptance, so a simultaneous pair at an edge degrades to one side.
    assign w_acc = w_en & ~full  & ~flush;
    assign r_acc = r_en & ~empty & ~flush;

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            cnt_d   = '0;
        end else begin
            ovf_d = w_en & full;
            udf_d = r_en & empty;
            if (w_acc) begin
                w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + PW'(1);
            end
            if (r_acc) begin
                r_ptr_d = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + PW'(1);
            end
            case ({w_acc, r_acc})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_ram #(
        .depth      (depth),
        .data_width (data_width)
    ) u_ram (
        .clk   (clk),
        .we    (w_acc),
        .waddr (w_ptr_q),
        .wdata (data_in),
        .raddr (r_ptr_q),
        .rdata (rd_data)
    );

    if (fwft == FIFO_FWFT) begin : g_fwft
        assign data_out = rd_data;
    end else begin : g_std
        logic [data_width-1:0] dout_q;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                dout_q <= '0;
            end else if (r_acc) begin
                dout_q <= rd_data;
            end
        end

        assign data_out = dout_q;
    end

endmodule
